// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, load-use bubble and taken-branch flush.
// Define HAZARD_CTRL_PERF_EN to add stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic        ex_memread_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  output logic        pc_stall_o,
  output logic        ifid_stall_o,
  output logic        ifid_flush_o,
  output logic        idex_bubble_o,
  output logic        idex_stall_o,
  output logic        exmem_stall_o,
  output logic        memwb_bubble_o,
`ifdef HAZARD_CTRL_PERF_EN
  output logic [31:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o,
`endif
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT} state_t;

  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       err_nxt;
  logic       mem_wait, load_use, flush;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    mem_wait = start_i && (state != IDLE) && mem_req_i && !mem_ack_i;
    load_use = start_i && (state == RUN) && !mem_wait && ex_memread_i &&
               (ex_rd_i != 5'd0) && ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
    flush    = start_i && (state == RUN) && !mem_wait && !load_use && branch_taken_i;

    pc_stall_o     = mem_wait || load_use;
    ifid_stall_o   = mem_wait || load_use;
    ifid_flush_o   = flush;
    idex_bubble_o  = load_use;
    idex_stall_o   = mem_wait;
    exmem_stall_o  = mem_wait;
    memwb_bubble_o = mem_wait;
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = err_o;
    if (!start_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = RUN;
        RUN: begin
          if (mem_wait) begin
            state_nxt    = MEM_WAIT;
            wait_cnt_nxt = 8'd0;
          end
        end
        MEM_WAIT: begin
          // Timeout is judged on the count held during this cycle, so err lands one edge later.
          if (wait_cnt >= TIMEOUT) err_nxt = 1'b1;
          wait_cnt_nxt = sat_inc(wait_cnt);
          if (mem_ack_i || !mem_req_i) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      err_o    <= err_nxt;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 16'd0;
    end else begin
      if (pc_stall_o)   stall_cnt_o <= stall_cnt_o + 32'd1;
      if (ifid_flush_o) flush_cnt_o <= flush_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch flush, priority, memory wait,
// timeout (second instance with TIMEOUT_CYCLES=3), async reset and start gating.
module tb_hazard_ctrl;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] MW   = 7'b1100111;
  localparam logic [6:0] LU   = 7'b1101000;
  localparam logic [6:0] BR   = 7'b0010000;

  logic       clk_i, rst_i, start_i;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic       ex_memread_i, branch_taken_i, mem_req_i, mem_ack_i;

  logic pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_stall, memwb_bubble, err;
  logic pc_stall_t, ifid_stall_t, ifid_flush_t, idex_bubble_t, idex_stall_t, exmem_stall_t,
        memwb_bubble_t, err_t;
  logic [6:0] ctl, ctl_t;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt, stall_cnt_t;
  logic [15:0] flush_cnt, flush_cnt_t;
  logic [15:0] flush_base;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  assign ctl   = {pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_stall, exmem_stall, memwb_bubble};
  assign ctl_t = {pc_stall_t, ifid_stall_t, ifid_flush_t, idex_bubble_t, idex_stall_t,
                  exmem_stall_t, memwb_bubble_t};

  hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_stall_o(pc_stall), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
    .idex_bubble_o(idex_bubble), .idex_stall_o(idex_stall), .exmem_stall_o(exmem_stall),
    .memwb_bubble_o(memwb_bubble),
`ifdef HAZARD_CTRL_PERF_EN
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
`endif
    .err_o(err)
  );

  hazard_ctrl #(.TIMEOUT_CYCLES(3)) dut_to (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_stall_o(pc_stall_t), .ifid_stall_o(ifid_stall_t), .ifid_flush_o(ifid_flush_t),
    .idex_bubble_o(idex_bubble_t), .idex_stall_o(idex_stall_t), .exmem_stall_o(exmem_stall_t),
    .memwb_bubble_o(memwb_bubble_t),
`ifdef HAZARD_CTRL_PERF_EN
    .stall_cnt_o(stall_cnt_t), .flush_cnt_o(flush_cnt_t),
`endif
    .err_o(err_t)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #2;
  endtask

  task automatic clear_in;
    id_rs1_i = 5'd0; id_rs2_i = 5'd0; ex_rd_i = 5'd0;
    ex_memread_i = 1'b0; branch_taken_i = 1'b0; mem_req_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  task automatic set_lu;
    ex_memread_i = 1'b1; ex_rd_i = 5'd5; id_rs2_i = 5'd5;
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0;
    clear_in();
    #3;
    check("reset_ctl", 32'(ctl), 32'(NONE));
    check("reset_err", 32'(err), 32'd0);
    #10;
    rst_i = 1'b1; start_i = 1'b1;
    tick();

    // load-use on rs2, one cycle only
    set_lu(); #1;
    check("lu_rs2", 32'(ctl), 32'(LU));
    tick(); clear_in(); #1;
    check("lu_released", 32'(ctl), 32'(NONE));
    // rd=0 never hazards, even when it matches rs1=0
    ex_memread_i = 1'b1; ex_rd_i = 5'd0; id_rs2_i = 5'd5; #1;
    check("lu_rd0", 32'(ctl), 32'(NONE));
    ex_rd_i = 5'd7; id_rs1_i = 5'd7; id_rs2_i = 5'd3; #1;
    check("lu_rs1", 32'(ctl), 32'(LU));
    ex_memread_i = 1'b0; #1;
    check("no_load", 32'(ctl), 32'(NONE));
    tick(); clear_in();

    // branch flush for one cycle
    branch_taken_i = 1'b1; #1;
    check("branch", 32'(ctl), 32'(BR));
    tick(); branch_taken_i = 1'b0; #1;
    check("branch_end", 32'(ctl), 32'(NONE));

    // priority
    set_lu(); branch_taken_i = 1'b1; #1;
    check("prio_lu_br", 32'(ctl), 32'(LU));
    mem_req_i = 1'b1; #1;
    check("prio_mw", 32'(ctl), 32'(MW));
    clear_in(); tick();

    // memory wait 4 cycles then ack
    mem_req_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("mw_freeze%0d", i), 32'(ctl), 32'(MW));
      tick();
    end
    mem_ack_i = 1'b1; #1;
    check("mw_ack_cycle", 32'(ctl), 32'(NONE));
    tick(); clear_in();
    set_lu(); #1;
    check("mw_back_run", 32'(ctl), 32'(LU));
    check("mw_err", 32'(err), 32'd0);
    clear_in();

    // timeout on the TIMEOUT_CYCLES=3 instance
    #1 rst_i = 1'b0; #1 rst_i = 1'b1;
    tick();
    mem_req_i = 1'b1;
    tick();
    for (int e = 2; e <= 10; e++) begin
      tick();
      check($sformatf("to_err_e%0d", e), 32'(err_t), (e >= 5) ? 32'd1 : 32'd0);
    end
    check("to_stall_held", 32'(ctl_t), 32'(MW));
    mem_ack_i = 1'b1; tick(); clear_in(); tick();
    check("to_err_sticky", 32'(err_t), 32'd1);

    // async reset mid-MEM_WAIT
    mem_req_i = 1'b1; tick(); #1;
    check("mw_before_rst", 32'(ctl), 32'(MW));
    rst_i = 1'b0; #1;
    check("async_rst_ctl", 32'(ctl), 32'(NONE));
    check("async_rst_err", 32'(err_t), 32'd0);
    rst_i = 1'b1; #1;
    check("idle_after_rst", 32'(ctl), 32'(NONE));
    mem_req_i = 1'b0; tick();
    check("no_residual", 32'(ctl), 32'(NONE));

    // start gating
    set_lu(); start_i = 1'b0; #1;
    check("start_low", 32'(ctl), 32'(NONE));
    tick(); start_i = 1'b1; #1;
    check("idle_gated", 32'(ctl), 32'(NONE));
    tick();
    check("restart_run", 32'(ctl), 32'(LU));
    clear_in();

`ifdef HAZARD_CTRL_PERF_EN
    dut.stall_cnt_o = 32'hFFFF_FFFF;
    set_lu(); tick(); clear_in();
    check("stall_wrap", stall_cnt, 32'd0);
    flush_base = flush_cnt;
    branch_taken_i = 1'b1; tick(); branch_taken_i = 1'b0; tick();
    check("flush_cnt", 32'(flush_cnt), 32'(flush_base + 16'd1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
